// File: rtl/quat_euler_cordic.sv
// Quaternion to ZYX Euler angles (roll, pitch, yaw in degrees Q(OUT_FRAC)).
// One vectoring-mode CORDIC engine is time-shared across the three atan2 evaluations.
module quat_euler_cordic #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 32,
  parameter int OUT_FRAC = 16,
  parameter int ITER     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  quat_w,
  input  logic [IN_W-1:0]  quat_x,
  input  logic [IN_W-1:0]  quat_y,
  input  logic [IN_W-1:0]  quat_z,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] roll,
  output logic [OUT_W-1:0] pitch,
  output logic [OUT_W-1:0] yaw,
  output logic             sat
);

  localparam int CW    = IN_W + 2;
  localparam int FRAC  = IN_W - 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic signed [CW-1:0]    ONE    = CW'(1) << FRAC;
  localparam logic signed [CW-1:0]    INV_K  = CW'($rtoi(0.6072529350088813 * (2.0 ** FRAC)));
  localparam logic signed [OUT_W-1:0] DEG90  = OUT_W'(90) << OUT_FRAC;
  localparam logic signed [OUT_W-1:0] DEG180 = OUT_W'(180) << OUT_FRAC;
  localparam logic signed [OUT_W-1:0] DEG360 = OUT_W'(360) << OUT_FRAC;

  typedef enum logic [3:0] {
    IDLE, PROD, ARG, PRE_R, IT_R, PRE_P, IT_P, PRE_Y, IT_Y, FIN
  } state_t;

  state_t state;

  logic signed [IN_W-1:0]  qw, qx, qy, qz;
  logic signed [CW-1:0]    p_wx, p_yz, p_wy, p_zx, p_wz, p_xy, p_xx, p_yy, p_zz;
  logic signed [CW-1:0]    rn, rd, s_arg, yn, yd;
  logic                    sat_arg;
  logic signed [CW-1:0]    cx, cy;
  logic signed [OUT_W-1:0] cz;
  logic                    zero_y;
  logic [CNT_W-1:0]        iter;
  logic signed [OUT_W-1:0] ang_r, ang_p;

  logic signed [CW-1:0]    sx, sy, s_raw, cos_p, src_x, src_y;
  logic signed [2*CW-1:0]  kprod;
  logic signed [OUT_W-1:0] atan_cur;
  logic signed [OUT_W-1:0] atan_rom [ITER];

  function automatic real atan_deg(input int i);
    case (i)
      0:       return 45.0;
      1:       return 26.56505117707799;
      2:       return 14.036243467926479;
      3:       return 7.125016348901798;
      4:       return 3.5763343749973511;
      5:       return 1.7899106082460694;
      6:       return 0.8951737102110744;
      7:       return 0.4476141708605531;
      8:       return 0.2238105003685381;
      9:       return 0.1119056770662069;
      10:      return 0.0559528918938037;
      11:      return 0.0279764526170037;
      12:      return 0.0139882271422650;
      default: return 57.29577951308232 / (2.0 ** i);
    endcase
  endfunction

  function automatic logic signed [CW-1:0] qmul(input logic signed [IN_W-1:0] a,
                                                input logic signed [IN_W-1:0] b);
    logic signed [2*IN_W-1:0] p;
    p = a * b;
    return CW'(p >>> FRAC);
  endfunction

  function automatic logic signed [OUT_W-1:0] wrap180(input logic signed [OUT_W-1:0] a);
    if (a > DEG180)   return a - DEG360;
    if (a <= -DEG180) return a + DEG360;
    return a;
  endfunction

  for (genvar g = 0; g < ITER; g++) begin : g_rom
    assign atan_rom[g] = OUT_W'($rtoi(atan_deg(g) * (2.0 ** OUT_FRAC) + 0.5));
  end

  assign sx       = cx >>> iter;
  assign sy       = cy >>> iter;
  assign atan_cur = atan_rom[iter];
  assign s_raw    = (p_wy - p_zx) <<< 1;
  assign kprod    = cx * INV_K;
  // A clamped pitch argument means |sin(pitch)| = 1, so cos(pitch) is exactly zero.
  assign cos_p    = sat_arg ? '0 : CW'(kprod >>> FRAC);

  always_comb begin
    src_x = yd;
    src_y = yn;
    case (state)
      PRE_R:   begin src_x = rd;    src_y = rn;    end
      PRE_P:   begin src_x = cos_p; src_y = s_arg; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      roll    <= '0;
      pitch   <= '0;
      yaw     <= '0;
      sat     <= 1'b0;
      qw      <= '0;
      qx      <= '0;
      qy      <= '0;
      qz      <= '0;
      p_wx    <= '0;
      p_yz    <= '0;
      p_wy    <= '0;
      p_zx    <= '0;
      p_wz    <= '0;
      p_xy    <= '0;
      p_xx    <= '0;
      p_yy    <= '0;
      p_zz    <= '0;
      rn      <= '0;
      rd      <= '0;
      s_arg   <= '0;
      yn      <= '0;
      yd      <= '0;
      sat_arg <= 1'b0;
      cx      <= '0;
      cy      <= '0;
      cz      <= '0;
      zero_y  <= 1'b0;
      iter    <= '0;
      ang_r   <= '0;
      ang_p   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            qw    <= quat_w;
            qx    <= quat_x;
            qy    <= quat_y;
            qz    <= quat_z;
            busy  <= 1'b1;
            state <= PROD;
          end
        end
        PROD: begin
          p_wx  <= qmul(qw, qx);
          p_yz  <= qmul(qy, qz);
          p_wy  <= qmul(qw, qy);
          p_zx  <= qmul(qz, qx);
          p_wz  <= qmul(qw, qz);
          p_xy  <= qmul(qx, qy);
          p_xx  <= qmul(qx, qx);
          p_yy  <= qmul(qy, qy);
          p_zz  <= qmul(qz, qz);
          state <= ARG;
        end
        ARG: begin
          rn <= (p_wx + p_yz) <<< 1;
          rd <= ONE - ((p_xx + p_yy) <<< 1);
          yn <= (p_wz + p_xy) <<< 1;
          yd <= ONE - ((p_yy + p_zz) <<< 1);
          if (s_raw > ONE) begin
            s_arg   <= ONE;
            sat_arg <= 1'b1;
          end else if (s_raw < -ONE) begin
            s_arg   <= -ONE;
            sat_arg <= 1'b1;
          end else begin
            s_arg   <= s_raw;
            sat_arg <= 1'b0;
          end
          state <= PRE_R;
        end
        PRE_R, PRE_P, PRE_Y: begin
          // Fold the left half-plane into the right one so CORDIC only spans +-90 deg.
          if (src_x[CW-1]) begin
            cx <= -src_x;
            cy <= -src_y;
            cz <= src_y[CW-1] ? -DEG180 : DEG180;
          end else begin
            cx <= src_x;
            cy <= src_y;
            cz <= '0;
          end
          zero_y <= (src_y == '0);
          iter   <= '0;
          if (state == PRE_R) begin
            state <= IT_R;
          end else if (state == PRE_P) begin
            ang_r <= cz;
            state <= IT_P;
          end else begin
            ang_p <= (cz > DEG90) ? DEG90 : ((cz < -DEG90) ? -DEG90 : cz);
            state <= IT_Y;
          end
        end
        IT_R, IT_P, IT_Y: begin
          // A vector starting on the axis keeps its preload angle exactly; x still gains K.
          if (!cy[CW-1]) begin
            cx <= cx + sy;
            cy <= cy - sx;
            if (!zero_y) cz <= cz + atan_cur;
          end else begin
            cx <= cx - sy;
            cy <= cy + sx;
            if (!zero_y) cz <= cz - atan_cur;
          end
          iter <= iter + CNT_W'(1);
          if (iter == CNT_W'(ITER - 1)) begin
            if (state == IT_R)      state <= PRE_P;
            else if (state == IT_P) state <= PRE_Y;
            else                    state <= FIN;
          end
        end
        FIN: begin
          // In gimbal lock roll is not separable from yaw, so it is reported as zero.
          roll  <= sat_arg ? '0 : wrap180(ang_r);
          pitch <= ang_p;
          yaw   <= wrap180(cz);
          sat   <= sat_arg;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quat_euler_cordic.sv
// Directed bench for quat_euler_cordic: hand-computed angles, latency, handshake and reset abort.
module tb_quat_euler_cordic;

  localparam longint TOL  = 656;
  localparam longint D30  = 30 * 65536;
  localparam longint D90  = 90 * 65536;
  localparam longint D135 = 135 * 65536;
  localparam longint D180 = 180 * 65536;
  localparam int     LAT  = 54;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] quat_w, quat_x, quat_y, quat_z;
  logic        busy, done, sat;
  logic [31:0] roll, pitch, yaw;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int cnt0;
  int lat;

  quat_euler_cordic dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .quat_w (quat_w),
    .quat_x (quat_x),
    .quat_y (quat_y),
    .quat_z (quat_z),
    .busy   (busy),
    .done   (done),
    .roll   (roll),
    .pitch  (pitch),
    .yaw    (yaw),
    .sat    (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic checkOutput(input string tag, input longint got, input longint exp,
                             input longint tol);
    longint diff;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    compared++;
    if (diff > tol) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] z);
    @(negedge clk);
    quat_w = w;
    quat_x = x;
    quat_y = y;
    quat_z = z;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic checkVector(input string name,
                             input logic [31:0] w, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] z,
                             input longint er, input longint tr,
                             input longint ep, input longint tp,
                             input longint ey, input longint ty,
                             input logic es);
    int cyc;
    applyStimulus(w, x, y, z);
    checkOutput({name, "_busy"}, busy, 1, 0);
    waitDone(cyc);
    checkOutput({name, "_latency"}, cyc, LAT, 0);
    checkOutput({name, "_roll"}, $signed(roll), er, tr);
    checkOutput({name, "_pitch"}, $signed(pitch), ep, tp);
    checkOutput({name, "_yaw"}, $signed(yaw), ey, ty);
    checkOutput({name, "_sat"}, sat, es, 0);
    checkOutput({name, "_busy_at_done"}, busy, 0, 0);
    @(posedge clk);
    #1;
    checkOutput({name, "_done_pulse"}, done, 0, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    quat_w = '0;
    quat_x = '0;
    quat_y = '0;
    quat_z = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_roll", $signed(roll), 0, 0);
    checkOutput("reset_pitch", $signed(pitch), 0, 0);
    checkOutput("reset_yaw", $signed(yaw), 0, 0);
    checkOutput("reset_sat", sat, 0, 0);
    checkOutput("reset_busy", busy, 0, 0);
    checkOutput("reset_done", done, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed angle vectors");
    checkVector("identity", 32'h40000000, 32'h0, 32'h0, 32'h0,
                0, TOL, 0, TOL, 0, TOL, 1'b0);
    checkVector("yaw90", 32'h2D413CCD, 32'h0, 32'h0, 32'h2D413CCD,
                0, TOL, 0, TOL, D90, TOL, 1'b0);
    checkVector("roll180", 32'h0, 32'h40000000, 32'h0, 32'h0,
                D180, 0, 0, TOL, 0, TOL, 1'b0);
    checkVector("pitch30", 32'h3DD1BB48, 32'h0, 32'h10907E2D, 32'h0,
                0, TOL, D30, TOL, 0, TOL, 1'b0);
    checkVector("pitch_m30", 32'h3DD1BB48, 32'h0, 32'hEF6F81D3, 32'h0,
                0, TOL, -D30, TOL, 0, TOL, 1'b0);
    checkVector("yaw_m135", 32'h187DE2A7, 32'h0, 32'h0, 32'hC4DF2861,
                0, TOL, 0, TOL, -D135, TOL, 1'b0);
    checkVector("gimbal", 32'h30000000, 32'h0, 32'h30000000, 32'h0,
                0, 0, D90, TOL, D180, 0, 1'b1);

    $display("[TB] start while busy and in the done cycle");
    cnt0 = done_cnt;
    applyStimulus(32'h2D413CCD, 32'h0, 32'h0, 32'h2D413CCD);
    repeat (10) @(posedge clk);
    @(negedge clk);
    quat_w = 32'h0;
    quat_x = 32'h40000000;
    quat_y = 32'h0;
    quat_z = 32'h0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("busy_start_yaw", $signed(yaw), D90, TOL);
    checkOutput("busy_start_roll", $signed(roll), 0, TOL);
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("done_cycle_start_ignored", busy, 0, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("after_done_accept", busy, 1, 0);
    waitDone(lat);
    checkOutput("after_done_latency", lat, LAT, 0);
    checkOutput("after_done_roll", $signed(roll), D180, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count", done_cnt - cnt0, 2, 0);

    $display("[TB] reset in the middle of a conversion");
    checkVector("pre_reset_gimbal", 32'h30000000, 32'h0, 32'h30000000, 32'h0,
                0, 0, D90, TOL, D180, 0, 1'b1);
    applyStimulus(32'h2D413CCD, 32'h0, 32'h0, 32'h2D413CCD);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cnt0 = done_cnt;
    checkOutput("abort_pitch", $signed(pitch), 0, 0);
    checkOutput("abort_yaw", $signed(yaw), 0, 0);
    checkOutput("abort_sat", sat, 0, 0);
    checkOutput("abort_busy", busy, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_cnt - cnt0, 0, 0);
    checkVector("post_reset_pitch30", 32'h3DD1BB48, 32'h0, 32'h10907E2D, 32'h0,
                0, TOL, D30, TOL, 0, TOL, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quat_euler_cordic.md
Name: quat_euler_cordic

Overview:
Iterative, parametrised quaternion-to-Euler converter (ZYX yaw-pitch-roll) for the BNO08x sensor-fusion path. It uses one shared vectoring-mode CORDIC engine in place of linear approximations. It accepts a unit quaternion in signed Q(IN_W-2) and returns roll, pitch and yaw in signed degrees Q(OUT_FRAC). It sits between the SPI report parser and the downstream display/telemetry logic, with a start/busy/done handshake.

Parameters:
IN_W, 32, quaternion component width; format signed Q(IN_W-2), so the default is Q30.
OUT_W, 32, angle output width, signed.
OUT_FRAC, 16, fractional bits of the output angles, in degrees.
ITER, 16, CORDIC iterations per angle; legal range 8..(IN_W-4).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
quat_w  in  IN_W  quaternion w, signed Q(IN_W-2)
quat_x  in  IN_W  quaternion x
quat_y  in  IN_W  quaternion y
quat_z  in  IN_W  quaternion z
busy  out  1  high from the accept edge until done
done  out  1  one-cycle pulse when outputs are valid
roll  out  OUT_W  degrees Q(OUT_FRAC), range (-180,+180]
pitch  out  OUT_W  degrees Q(OUT_FRAC), range [-90,+90]
yaw  out  OUT_W  degrees Q(OUT_FRAC), range (-180,+180]
sat  out  1  pitch argument clamped this conversion

Behaviour:
- Reset: all outputs are 0, FSM in IDLE. Reset mid-operation aborts the conversion immediately; no done is issued.
- Accept: in IDLE with start=1, the quaternion is registered and busy rises on the same edge.
  - start is ignored while busy, including in the cycle done is high.
  - A new start is accepted in the cycle after done.
- FSM sequence: IDLE -> PROD -> ARG -> PRE_R -> IT_R (ITER cycles) -> PRE_P -> IT_P (ITER cycles) -> PRE_Y -> IT_Y (ITER cycles) -> FIN -> IDLE.
- PROD: nine signed products (wx, yz, wy, zx, wz, xy, x², y², z²), each 2*IN_W bits, arithmetic-shifted right by IN_W-2.
- ARG computes the following, and clamps s to ±1.0 (setting sat) if |s|>1:
  - rn = 2(wx+yz)
  - rd = 1-2(x²+y²)
  - s = 2(wy-zx)
  - yn = 2(wz+xy)
  - yd = 1-2(y²+z²)
- CORDIC datapath is IN_W+2 bits signed, to absorb the gain of 1.6468 and sqrt2 growth. The angle accumulator works directly in degrees Q(OUT_FRAC) from an atan(2^-i) ROM, so no rad-to-deg multiply is needed.
- PRE_x (quadrant pre-rotation): if the x input is negative, negate x and y and preload the angle accumulator with +180 (if y>=0) or -180 (if y<0).
- Vectoring iterations: drive y toward 0; one iteration per cycle; shift amount equals the iteration counter.
- Roll: vector (rd, rn). The final x magnitude, multiplied by 1/K (constant 0.60725, Q(IN_W-2)) in PRE_P, gives cos(pitch) >= 0.
- Pitch: vector (cos(pitch), s). No sqrt or asin is used.
- Yaw: vector (yd, yn).
- atan2(0,0) = 0. This is the gimbal-lock case: roll is reported as 0.
- atan2(0,negative) = +180 exactly (preload only, no iterations move the angle).
- FIN: roll, pitch, yaw and sat are registered together; done=1 and busy=0 on the next edge.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+3*ITER+6 (54 cycles for ITER=16).
- Outputs hold their values until the next FIN. sat reflects only the most recent conversion.
- Accuracy: for a normalised input with ITER=16, |error| <= 0.01° versus a double-precision reference on every angle.

Test Plan:
- Identity quaternion: w=0x40000000, x=y=z=0 -> roll=pitch=yaw=0 (±0x0290), sat=0, done pulses exactly 1 cycle, 54 cycles after accept.
- Yaw 90: w=z=0x2D413CCD -> yaw=0x005A0000 ±0x0290, roll=pitch≈0.
- Roll 180: x=0x40000000, others 0 -> roll=+0x00B40000 (not -180), pitch=yaw≈0.
- Pitch 30: w=0x3DD1BB48 (cos 15°), y=0x10907E2D (sin 15°) -> pitch=0x001E0000 ±0x0290.
- Saturation / gimbal: w=y=0x30000000 (s=1.125) -> sat=1, pitch=0x005A0000, roll=0.
- Handshake: pulse start while busy -> ignored, single done. Assert rst_n=0 at cycle 20 -> outputs 0, no done; next start completes normally.
